spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
SPI shift engine that consumes the CPU-visible SPI register bank (BITRATE, DATA_OUT, CTRL) and produces DATA_IN, plus the physical SPI pins. It sits directly downstream of the memory-mapped SPI register interface, on the same CPU clock. Each transfer is full-duplex, 8/16/24/32 bits, in all four CPOL/CPHA modes, with two chip selects. Transfers are triggered by a rising edge on CTRL.start.

Parameters:
DIV_W, 16, width of the SCLK half-period counter; only spi_bitrate[DIV_W-1:0] is used.
NUM_CS, 2, number of chip-select outputs; must be 2 for the CTRL map below.

Ports:
clk  in  1  CPU clock.
rst  in  1  reset, synchronous, active-high.
spi_bitrate  in  32  SCLK half-period in clk cycles; value 0 is treated as 1.
spi_data_out  in  32  transmit word, right-aligned.
spi_ctrl  in  9  [0] start, [1] cpol, [2] cpha, [3] lsb_first, [5:4] len (0=8, 1=16, 2=24, 3=32 bits), [6] cs_sel, [7] cs_hold, [8] loopback.
spi_data_in  out  32  received word, right-aligned, with upper bits zero.
busy  out  1  high while a transfer is in progress.
done  out  1  one-cycle pulse at end of transfer.
sclk  out  1  SPI clock.
mosi  out  1  master data out.
miso  in  1  master data in.
cs_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset values: spi_data_in=0, busy=0, done=0, sclk=0, mosi=0, cs_n=all 1s, FSM=IDLE, start_q=0. Reset mid-transfer aborts immediately with no done pulse.
- Start detect: start_q is a registered copy of spi_ctrl[0]. A start occurs when spi_ctrl[0]=1 and start_q=0, while in IDLE.
  - A start edge seen while busy is dropped; it is not queued.
  - A level held high does not retrigger.
- On start: latch HALF=max(bitrate[DIV_W-1:0],1), N=8*(len+1), cpol, cpha, lsb_first, cs_sel, cs_hold, loopback, data_out. Later register changes have no effect until the next start.
- FSM:
  - IDLE: sclk follows spi_ctrl[1] (registered).
  - start -> SETUP: next cycle busy=1 and cs_n[cs_sel]=0. With cpha=0, mosi drives the first bit.
  - SETUP: HALF cycles -> SHIFT.
  - SHIFT: 2N SCLK edges, HALF cycles apart; the first edge occurs at the end of SETUP.
    - cpha=0: sample on the leading edge, shift mosi on the trailing edge.
    - cpha=1: shift on the leading edge, sample on the trailing edge.
    - After the 2N-th edge sclk equals cpol -> HOLD.
  - HOLD: HALF cycles -> DONE.
  - DONE (1 cycle): done=1, busy=0, spi_data_in updated. cs_n deasserts this cycle unless cs_hold=1 -> IDLE.
- Timing: done asserts exactly HALF*(2N+2) cycles after busy rises.
- Bit order: lsb_first=0 transmits bit N-1 first; lsb_first=1 transmits bit 0 first. Received bits are assembled in the same order into bits [N-1:0]; bits [31:N]=0.
- loopback=1: the sampled bit is taken from internal mosi and the miso pin is ignored. Pins still toggle.
- cs_hold: after DONE the selected cs_n stays low while ctrl[7]=1. It deasserts on the first IDLE cycle with ctrl[7]=0. A new start with a different cs_sel deasserts the old CS and asserts the new one on the same cycle.
- spi_data_in holds its value between transfers; it changes only in DONE.
- mosi in IDLE holds its last value.

Test Plan:
1. Mode 0, MSB first. bitrate=2, ctrl=0x001 (len 8), data_out=0xA5, miso driven from slave model returning 0x3C. Required: cs_n=2'b10, 8 rising edges with mosi sequence 1,0,1,0,0,1,0,1; done 36 cycles after busy rises; data_in=0x0000003C; cs_n=2'b11 in the done cycle.
2. All four modes, 32 bits, loopback. ctrl[8]=1, len=3, data_out=0xDEADBEEF, bitrate=1, each cpol/cpha combination. Required: data_in=0xDEADBEEF; sclk idle level equals cpol; done after 66 cycles.
3. LSB first, 16 bits. data_out=0x0001, lsb_first=1, cs_sel=1, loopback. Required: first mosi bit =1; cs_n=2'b01; data_in=0x00000001.
4. Config and retrigger robustness. Change bitrate and data_out mid-transfer, and pulse start again while busy. Required: the transfer completes with the original config; exactly one done pulse; no second transfer. bitrate=0 behaves identically to bitrate=1.
5. cs_hold chaining. Run two 8-bit transfers with ctrl[7]=1, then clear ctrl[7]. Required: cs_n stays low across both transfers and between them; it rises one cycle after ctrl[7] clears in IDLE.
6. Reset mid-SHIFT. Assert rst for 1 cycle at edge 5 of 8. Required: next cycle busy=0, cs_n=2'b11, sclk=0, data_in=0, no done pulse; a subsequent start works normally.

Source files
------------

// File: rtl/spi_master_core.sv
// Full-duplex SPI shift engine: 8/16/24/32-bit transfers in all four CPOL/CPHA modes,
// two chip selects, optional internal loopback and chip-select hold between transfers.
module spi_master_core #(
  parameter int DIV_W  = 16,
  parameter int NUM_CS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       spi_bitrate,
  input  logic [31:0]       spi_data_out,
  input  logic [8:0]        spi_ctrl,
  output logic [31:0]       spi_data_in,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  // The transmit word is pre-aligned so the outgoing bit is always at bit 31 (MSB first) or bit 0.
  function automatic logic out_bit(input logic [31:0] w, input logic lsb);
    return lsb ? w[0] : w[31];
  endfunction

  function automatic logic [31:0] shift_tx(input logic [31:0] w, input logic lsb);
    return lsb ? {1'b0, w[31:1]} : {w[30:0], 1'b0};
  endfunction

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [6:0]        edge_q, edge_d;
  logic [1:0]        len_q, len_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              hold_q, hold_d;
  logic              loop_q, loop_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       data_in_q, data_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;

  logic [DIV_W-1:0]  half_s;
  logic [6:0]        two_n_s;
  logic [6:0]        edge_nxt_s;
  logic [4:0]        shamt_s;
  logic              leading_s;
  logic              drive_s;
  logic              sample_s;
  logic              edge_go_s;
  logic [31:0]       tx_load_s;
  logic              unused_bits;

  assign unused_bits = ^spi_bitrate[31:DIV_W];
  assign half_s      = (spi_bitrate[DIV_W-1:0] == '0) ? DIV_ONE : spi_bitrate[DIV_W-1:0];
  assign two_n_s     = {({1'b0, len_q} + 3'd1), 4'b0000};
  assign shamt_s     = {~len_q, 3'b000};
  assign edge_nxt_s  = edge_q + 7'd1;
  // Odd-numbered edges (edge_q even before the toggle) are leading edges.
  assign leading_s   = ~edge_q[0];
  assign drive_s     = cpha_q ? leading_s : (~leading_s && (edge_nxt_s != two_n_s));
  assign sample_s    = loop_q ? mosi_q : miso;

  // Next-state and datapath logic for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    start_d   = spi_ctrl[0];
    cnt_d     = cnt_q;
    half_d    = half_q;
    edge_d    = edge_q;
    len_d     = len_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    hold_d    = hold_q;
    loop_d    = loop_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_in_d = data_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    edge_go_s = 1'b0;
    tx_load_s = spi_ctrl[3] ? spi_data_out : (spi_data_out << {~spi_ctrl[5:4], 3'b000});

    case (state_q)
      IDLE: begin
        sclk_d = spi_ctrl[1];
        cs_n_d = spi_ctrl[7] ? cs_n_q : {NUM_CS{1'b1}};
        if (spi_ctrl[0] && !start_q) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          half_d  = half_s;
          cnt_d   = half_s - DIV_ONE;
          edge_d  = 7'd0;
          len_d   = spi_ctrl[5:4];
          cpol_d  = spi_ctrl[1];
          cpha_d  = spi_ctrl[2];
          lsb_d   = spi_ctrl[3];
          hold_d  = spi_ctrl[7];
          loop_d  = spi_ctrl[8];
          rx_d    = 32'd0;
          cs_n_d  = {NUM_CS{1'b1}};
          cs_n_d[spi_ctrl[6]] = 1'b0;
          if (spi_ctrl[2]) begin
            tx_d = tx_load_s;
          end else begin
            mosi_d = out_bit(tx_load_s, spi_ctrl[3]);
            tx_d   = shift_tx(tx_load_s, spi_ctrl[3]);
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d   = SHIFT;
          edge_go_s = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_ONE;
        end
      end
      SHIFT: begin
        // The half period following the final edge is still spent in SHIFT.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_ONE;
        end else if (edge_q == two_n_s) begin
          state_d = HOLD;
          cnt_d   = half_q - DIV_ONE;
        end else begin
          edge_go_s = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          data_in_d = lsb_q ? (rx_q >> shamt_s) : rx_q;
          cs_n_d    = hold_q ? cs_n_q : {NUM_CS{1'b1}};
        end else begin
          cnt_d = cnt_q - DIV_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (edge_go_s) begin
      cnt_d  = half_q - DIV_ONE;
      sclk_d = ~sclk_q;
      edge_d = edge_nxt_s;
      if (leading_s ^ cpha_q) begin
        rx_d = lsb_q ? {sample_s, rx_q[31:1]} : {rx_q[30:0], sample_s};
      end else begin
        rx_d = rx_q;
      end
      if (drive_s) begin
        mosi_d = out_bit(tx_q, lsb_q);
        tx_d   = shift_tx(tx_q, lsb_q);
      end else begin
        mosi_d = mosi_q;
      end
    end else begin
      edge_d = edge_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      half_q    <= DIV_ONE;
      edge_q    <= 7'd0;
      len_q     <= 2'd0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      hold_q    <= 1'b0;
      loop_q    <= 1'b0;
      tx_q      <= 32'd0;
      rx_q      <= 32'd0;
      data_in_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= {NUM_CS{1'b1}};
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      edge_q    <= edge_d;
      len_q     <= len_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      hold_q    <= hold_d;
      loop_q    <= loop_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign spi_data_in = data_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: a protocol-level SPI slave plus a transfer-level reference model.
module tb_spi_master_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] spi_bitrate;
  logic [31:0] spi_data_out;
  logic [8:0]  spi_ctrl;
  logic [31:0] spi_data_in;
  logic        busy, done, sclk, mosi, miso;
  logic [1:0]  cs_n;

  int checks = 0;
  int errors = 0;

  spi_master_core #(.DIV_W(16), .NUM_CS(2)) dut (
    .clk(clk), .rst(rst), .spi_bitrate(spi_bitrate), .spi_data_out(spi_data_out),
    .spi_ctrl(spi_ctrl), .spi_data_in(spi_data_in), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observation state (written only by the monitor process)
  int   cyc = 0, busy_cyc = 0, done_cyc = 0, done_cnt = 0, busy_rises = 0, edges_seen = 0;
  int   slv_pos = 0;
  logic [1:0] cs_at_busy = 2'b00, cs_at_done = 2'b00;
  logic sclk_at_done = 1'b0, prev_busy = 1'b0, prev_sclk = 1'b0, lead = 1'b0;
  logic mosi_bits[$];
  bit   cs_rose = 1'b0;
  bit   watch_cs = 1'b0;

  // Transfer model (written by the stimulus process)
  int          m_n = 8, e_half = 1, d0 = 0;
  bit          m_lsb = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
  logic [31:0] m_slave = 32'd0, e_in = 32'd0, e_mosi = 32'd0;
  logic [1:0]  e_cs_act = 2'b11, e_cs_done = 2'b11;

  function automatic logic slave_bit(input int i);
    if (i >= m_n) return 1'b0;
    return m_lsb ? m_slave[i] : m_slave[m_n-1-i];
  endfunction

  // SPI slave and bus monitor, evaluated on the falling clock edge
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !prev_busy) begin
        busy_cyc   = cyc;
        busy_rises++;
        edges_seen = 0;
        slv_pos    = 0;
        mosi_bits.delete();
        cs_at_busy = cs_n;
        if (!m_cpha) miso = slave_bit(0);
      end else if (busy && (sclk !== prev_sclk)) begin
        lead = (sclk != m_cpol);
        edges_seen++;
        if (lead ^ m_cpha) mosi_bits.push_back(mosi);
        if (m_cpha && lead) begin
          miso = slave_bit(slv_pos);
          slv_pos++;
        end else if (!m_cpha && !lead) begin
          slv_pos++;
          miso = slave_bit(slv_pos);
        end
      end
      prev_sclk = sclk;
      prev_busy = busy;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        cs_at_done   = cs_n;
        sclk_at_done = sclk;
      end
      if (watch_cs && cs_n !== 2'b10) cs_rose = 1'b1;
    end
  end

  task automatic start_xfer(input logic [31:0] br, input logic [31:0] data,
                            input logic [8:0] ctrl, input logic [31:0] slave);
    logic [63:0] mask;
    m_n     = 8 * (int'(ctrl[5:4]) + 1);
    m_lsb   = ctrl[3];
    m_cpol  = ctrl[1];
    m_cpha  = ctrl[2];
    m_slave = slave;
    e_half  = (br[15:0] == 16'd0) ? 1 : int'(br[15:0]);
    mask    = (64'd1 << m_n) - 64'd1;
    e_mosi  = data & mask[31:0];
    e_in    = (ctrl[8] ? data : slave) & mask[31:0];
    e_cs_act  = ctrl[6] ? 2'b01 : 2'b10;
    e_cs_done = ctrl[7] ? e_cs_act : 2'b11;
    d0 = done_cnt;
    @(negedge clk);
    spi_bitrate  = br;
    spi_data_out = data;
    spi_ctrl     = ctrl & 9'h1FE;
    repeat (2) @(negedge clk);
    spi_ctrl = ctrl | 9'h001;
    @(negedge clk);
    spi_ctrl = ctrl & 9'h1FE;
  endtask

  task automatic finish_xfer(input string tag);
    int k;
    logic [31:0] w;
    k = 0;
    while (done_cnt == d0 && k < 20000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq({tag, " done_seen"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, " data_in"}, spi_data_in, e_in);
    check_eq({tag, " latency"}, 32'(done_cyc - busy_cyc), 32'(e_half * (2 * m_n + 2)));
    w = 32'd0;
    for (int i = 0; i < mosi_bits.size() && i < m_n; i++) begin
      w[m_lsb ? i : (m_n - 1 - i)] = mosi_bits[i];
    end
    check_eq({tag, " mosi_word"}, w, e_mosi);
    check_eq({tag, " edges"}, 32'(edges_seen), 32'(2 * m_n));
    check_eq({tag, " cs_active"}, 32'(cs_at_busy), 32'(e_cs_act));
    check_eq({tag, " cs_done"}, 32'(cs_at_done), 32'(e_cs_done));
    check_eq({tag, " sclk_idle"}, 32'(sclk_at_done), 32'(m_cpol));
  endtask

  initial begin
    logic [8:0]  c;
    logic [31:0] br;
    int          k, rises0;

    rst = 1'b1;
    spi_bitrate  = 32'd0;
    spi_data_out = 32'd0;
    spi_ctrl     = 9'h000;
    repeat (3) @(negedge clk);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst sclk", 32'(sclk), 32'd0);
    check_eq("rst mosi", 32'(mosi), 32'd0);
    check_eq("rst cs_n", 32'(cs_n), 32'd3);
    check_eq("rst data_in", spi_data_in, 32'd0);
    rst = 1'b0;

    // Mode 0, MSB first, slave returns 0x3C
    start_xfer(32'd2, 32'h0000_00A5, 9'h000, 32'h0000_003C);
    finish_xfer("t1");

    // All four modes, 32-bit loopback
    for (int m = 0; m < 4; m++) begin
      c = 9'h130;
      c[1] = m[0];
      c[2] = m[1];
      start_xfer(32'd1, 32'hDEAD_BEEF, c, $urandom());
      finish_xfer($sformatf("t2_mode%0d", m));
    end

    // LSB first, 16 bits, chip select 1, loopback
    start_xfer(32'd1, 32'h0000_0001, 9'h158, 32'h0000_FFFF);
    finish_xfer("t3");
    check_eq("t3 first_mosi", 32'((mosi_bits.size() > 0) ? mosi_bits[0] : 1'b0), 32'd1);

    // Mid-transfer config changes and a start pulse while busy
    start_xfer(32'd3, 32'h0000_005A, 9'h100, 32'd0);
    repeat (10) @(negedge clk);
    spi_bitrate  = 32'd7;
    spi_data_out = 32'h0000_00FF;
    spi_ctrl     = 9'h101;
    @(negedge clk);
    spi_ctrl = 9'h100;
    finish_xfer("t4");
    rises0 = busy_rises;
    repeat (100) @(negedge clk);
    check_eq("t4 no_retrigger", 32'(busy_rises - rises0), 32'd0);
    check_eq("t4 one_done", 32'(done_cnt - d0), 32'd1);
    start_xfer(32'd0, $urandom(), 9'h100, 32'd0);
    finish_xfer("t4_br0");

    // cs_hold chaining across two transfers
    start_xfer(32'd2, 32'h0000_0096, 9'h080, 32'h0000_0069);
    finish_xfer("t5a");
    cs_rose  = 1'b0;
    watch_cs = 1'b1;
    start_xfer(32'd1, 32'h0000_003C, 9'h080, 32'h0000_00C3);
    finish_xfer("t5b");
    repeat (5) @(negedge clk);
    #1;
    check_eq("t5 cs_held", 32'(cs_rose), 32'd0);
    watch_cs = 1'b0;
    spi_ctrl = 9'h000;
    @(negedge clk);
    #1;
    check_eq("t5 cs_release", 32'(cs_n), 32'd3);

    // Reset in the middle of the shift phase
    start_xfer(32'd2, 32'h0000_00C3, 9'h000, 32'h0000_005A);
    @(negedge clk);
    #1;
    k = 0;
    while (edges_seen < 5 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("t6 reached_edge5", 32'(edges_seen), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check_eq("t6 busy", 32'(busy), 32'd0);
    check_eq("t6 cs_n", 32'(cs_n), 32'd3);
    check_eq("t6 sclk", 32'(sclk), 32'd0);
    check_eq("t6 data_in", spi_data_in, 32'd0);
    repeat (50) @(negedge clk);
    check_eq("t6 no_done", 32'(done_cnt - d0), 32'd0);
    start_xfer(32'd1, $urandom(), 9'h000, $urandom());
    finish_xfer("t6_after");

    // Randomized transfers
    for (int i = 0; i < 12; i++) begin
      c    = 9'($urandom());
      c[0] = 1'b0;
      c[7] = 1'b0;
      br   = 32'($urandom_range(0, 3));
      start_xfer(br, $urandom(), c, $urandom());
      finish_xfer($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
